prbs_chk23: RTL

Receive-side PRBS-23 checker: the bit-error-rate counterpart of `prbs_gen23`, which drives the transmit data path in validation builds. It sits at the end of the receive chain, after FEC decode and transport-block deshaping, and consumes the recovered byte stream. It self-synchronises to the PRBS-23 sequence and declares lock. While locked, it reports per-byte bit errors and accumulates bit and error counts for BER measurement.

---
 rtl/prbs_chk23.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/prbs_chk23.sv
//==============================================================================
//  Module      : prbs_chk23
//  Description : Receive-side PRBS-23 (x^23 + x^18 + 1) bit-error checker.
//                Self-synchronises to the recovered byte stream, declares
//                lock after a run of clean bytes, and, while locked, reports
//                per-byte bit errors and accumulates bit/error counts for
//                BER measurement.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
//  Parameters
//    pMSB_FIRST : 1 = byte MSB is the first sequence bit, 0 = LSB first
//    pLOCK_CNT  : consecutive clean bytes in SEARCH to enter LOCK (1..255)
//    pLOSS_CNT  : consecutive errored bytes in LOCK to drop to SEARCH (1..255)
//    pCNT_W     : width of the bit / error counters (8..48)
//
//  Ports
//    clk_h      in   1       : data-path clock
//    rst        in   1       : asynchronous active-high reset
//    ival       in   1       : input byte valid (no backpressure)
//    idat       in   8       : received byte
//    iclr       in   1       : synchronous clear of both counters
//    olock      out  1       : high while in LOCK
//    oerr_val   out  1       : one-cycle pulse for an errored byte in LOCK
//    oerr_bits  out  4       : popcount of error bits of the last byte
//    obit_cnt   out  pCNT_W  : bits checked in LOCK (saturating)
//    oerr_cnt   out  pCNT_W  : bit errors seen in LOCK (saturating)
//
//  Build option
//    PRBS_CHK23_BER_CNT_EN : when defined, the BER counters and iclr are
//                            built; otherwise both counters read 0 and
//                            iclr is ignored.
//==============================================================================
`default_nettype none

module prbs_chk23 #(
  parameter int pMSB_FIRST = 0,
  parameter int pLOCK_CNT  = 16,
  parameter int pLOSS_CNT  = 4,
  parameter int pCNT_W     = 32
) (
  input  logic              clk_h,
  input  logic              rst,
  input  logic              ival,
  input  logic [7:0]        idat,
  input  logic              iclr,
  output logic              olock,
  output logic              oerr_val,
  output logic [3:0]        oerr_bits,
  output logic [pCNT_W-1:0] obit_cnt,
  output logic [pCNT_W-1:0] oerr_cnt
);

  //--------------------------------------------------------------------------
  // State encoding
  //--------------------------------------------------------------------------
  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCK   = 1'b1;

  localparam logic [22:0] C_SEED      = 23'h7FFFFF;
  localparam logic [7:0]  C_LOCK_LAST = 8'(pLOCK_CNT - 1);
  localparam logic [7:0]  C_LOSS_LAST = 8'(pLOSS_CNT - 1);

  //--------------------------------------------------------------------------
  // Serial 8-step check of one byte within a single cycle.
  // Returns {next shift register, error mask aligned to byte bit positions}.
  // In SEARCH the register is loaded with received bits so it converges on
  // the transmitter state after 23 bits; in LOCK it free-runs on the
  // expected bits so a single channel error is counted exactly once.
  //--------------------------------------------------------------------------
  function automatic logic [30:0] f_check(
    input logic [22:0] s_in,
    input logic [7:0]  d,
    input logic        free_run
  );
    logic [22:0] s;
    logic [7:0]  err;
    logic        e;
    logic [2:0]  idx;
    s   = s_in;
    err = '0;
    for (int i = 0; i < 8; i++) begin
      idx      = (pMSB_FIRST != 0) ? 3'(7 - i) : 3'(i);
      e        = s[22] ^ s[17];
      err[idx] = e ^ d[idx];
      s        = {s[21:0], (free_run ? e : d[idx])};
    end
    return {s, err};
  endfunction

  function automatic logic [3:0] f_popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  //--------------------------------------------------------------------------
  // Registers and datapath wires
  //--------------------------------------------------------------------------
  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [22:0] r_sr;
  logic [22:0] w_sr_nxt;
  logic [7:0]  r_good;
  logic [7:0]  w_good_nxt;
  logic [7:0]  r_bad;
  logic [7:0]  w_bad_nxt;
  logic [7:0]  w_err_vec;
  logic [3:0]  w_err_pop;
  logic        w_clean;
  logic        w_in_lock;
  logic        w_err_val_nxt;
  logic [3:0]  w_err_bits_nxt;

  assign w_in_lock                = (r_state == ST_LOCK);
  assign {w_sr_nxt, w_err_vec}    = f_check(r_sr, idat, w_in_lock);
  assign w_err_pop                = f_popcount(w_err_vec);
  assign w_clean                  = (w_err_vec == 8'h00);

  //--------------------------------------------------------------------------
  // FSM: state register (also holds the run counters and shift register)
  //--------------------------------------------------------------------------
  always_ff @(posedge clk_h or posedge rst) begin
    if (rst) begin
      r_state <= ST_SEARCH;
      r_sr    <= C_SEED;
      r_good  <= '0;
      r_bad   <= '0;
    end else if (ival) begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_good  <= w_good_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  // The transition happens on the byte that completes the run, so the
  // registered olock moves on the following clock.
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    case (r_state)
      ST_SEARCH: begin
        if (w_clean) begin
          if (r_good == C_LOCK_LAST) begin
            w_state_nxt = ST_LOCK;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_good_nxt  = r_good + 8'd1;
          end
        end else begin
          w_good_nxt = '0;
        end
      end
      ST_LOCK: begin
        if (!w_clean) begin
          if (r_bad == C_LOSS_LAST) begin
            // Shift register keeps its content; SEARCH re-verifies it.
            w_state_nxt = ST_SEARCH;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_bad_nxt   = r_bad + 8'd1;
          end
        end else begin
          w_bad_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_good_nxt  = '0;
        w_bad_nxt   = '0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: output logic (values registered below)
  //--------------------------------------------------------------------------
  always_comb begin
    w_err_val_nxt  = 1'b0;
    w_err_bits_nxt = 4'd0;
    if (ival) begin
      w_err_bits_nxt = w_err_pop;
      w_err_val_nxt  = w_in_lock && !w_clean;
    end
  end

  always_ff @(posedge clk_h or posedge rst) begin
    if (rst) begin
      oerr_val  <= 1'b0;
      oerr_bits <= 4'd0;
    end else begin
      oerr_val  <= w_err_val_nxt;
      oerr_bits <= w_err_bits_nxt;
    end
  end

  assign olock = w_in_lock;

  //--------------------------------------------------------------------------
  // BER counters
  //--------------------------------------------------------------------------
`ifdef PRBS_CHK23_BER_CNT_EN
  localparam logic [pCNT_W:0] C_BYTE_BITS = (pCNT_W + 1)'(8);

  logic [pCNT_W-1:0] r_bit_cnt;
  logic [pCNT_W-1:0] r_err_cnt;
  logic [pCNT_W:0]   w_bit_sum;
  logic [pCNT_W:0]   w_err_sum;

  // One extra bit catches the carry so the counters hold at all-ones.
  assign w_bit_sum = {1'b0, r_bit_cnt} + C_BYTE_BITS;
  assign w_err_sum = {1'b0, r_err_cnt} + {{(pCNT_W - 3){1'b0}}, w_err_pop};

  always_ff @(posedge clk_h or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (iclr) begin
      r_bit_cnt <= '0;
      r_err_cnt <= '0;
    end else if (ival && w_in_lock) begin
      r_bit_cnt <= w_bit_sum[pCNT_W] ? {pCNT_W{1'b1}} : w_bit_sum[pCNT_W-1:0];
      r_err_cnt <= w_err_sum[pCNT_W] ? {pCNT_W{1'b1}} : w_err_sum[pCNT_W-1:0];
    end
  end

  assign obit_cnt = r_bit_cnt;
  assign oerr_cnt = r_err_cnt;
`else
  logic w_unused_iclr;
  assign w_unused_iclr = iclr;
  assign obit_cnt      = '0;
  assign oerr_cnt      = '0;
`endif

endmodule

`default_nettype wire
